// File: rtl/rv32_alu_decode_stage_if.sv
// Fetch/execute-facing handshake and decoded-bundle signals of the RV32I ID/EX stage.
// slave is the stage itself; master is the fetch/execute side driving it.
interface rv32_alu_decode_stage_if #(
  parameter int unsigned bitwidth = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         instr;
  logic [bitwidth-1:0] pc_in;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          ALUOp;
  logic                ALUSrc;
  logic [bitwidth-1:0] imm;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic [2:0]          funct3_out;
  logic [bitwidth-1:0] pc_out;
  logic                illegal;

  modport master (
    output in_valid, instr, pc_in, flush, out_ready,
    input  in_ready, out_valid, ALUOp, ALUSrc, imm, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch, funct3_out, pc_out, illegal
  );

  modport slave (
    input  in_valid, instr, pc_in, flush, out_ready,
    output in_ready, out_valid, ALUOp, ALUSrc, imm, rs1, rs2, rd,
           reg_write, mem_read, mem_write, branch, funct3_out, pc_out, illegal
  );
endinterface

// File: rtl/rv32_alu_decode_stage.sv
// RV32I ID/EX register: combinational decode of OP/OP-IMM/LOAD/STORE/BRANCH into
// ALU select, operand source, immediate and control strobes, with valid/ready/flush.
module rv32_alu_decode_stage #(
  parameter int unsigned bitwidth = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  rv32_alu_decode_stage_if.slave bus
);
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRA  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_BGEU = 4'b1011
  } alu_op_e;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]          funct7;
  logic [2:0]          funct3;
  logic [bitwidth-1:0] imm_i, imm_s, imm_b, imm_shamt;

  assign funct7    = bus.instr[31:25];
  assign funct3    = bus.instr[14:12];
  assign imm_i     = {{(bitwidth-12){bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s     = {{(bitwidth-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b     = {{(bitwidth-12){bus.instr[31]}}, bus.instr[7], bus.instr[30:25],
                      bus.instr[11:8], 1'b0};
  assign imm_shamt = {{(bitwidth-5){1'b0}}, bus.instr[24:20]};

  alu_op_e             d_op;
  logic                d_src, d_rw, d_mr, d_mw, d_br, d_illegal;
  logic [bitwidth-1:0] d_imm;
  logic [4:0]          d_rs2, d_rd;

  always_comb begin
    d_op      = ALU_ADD;
    d_src     = 1'b0;
    d_imm     = '0;
    d_rs2     = bus.instr[24:20];
    d_rd      = bus.instr[11:7];
    d_rw      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_br      = 1'b0;
    d_illegal = 1'b0;
    case (bus.instr[6:0])
      OPC_OP: begin
        d_rw = 1'b1;
        if (funct7 == 7'b0000000)                        d_op = base_op(funct3);
        else if (funct7 == 7'b0100000 && funct3 == 3'b000) d_op = ALU_SUB;
        else if (funct7 == 7'b0100000 && funct3 == 3'b101) d_op = ALU_SRA;
        else                                               d_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        d_src = 1'b1;
        d_rw  = 1'b1;
        d_rs2 = '0;
        d_imm = imm_i;
        d_op  = base_op(funct3);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          d_imm = imm_shamt;
          if (funct3 == 3'b101 && funct7 == 7'b0100000) d_op = ALU_SRA;
          else if (funct7 != 7'b0000000)                d_illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        d_src     = 1'b1;
        d_imm     = imm_i;
        d_mr      = 1'b1;
        d_rw      = 1'b1;
        d_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        d_src     = 1'b1;
        d_imm     = imm_s;
        d_mw      = 1'b1;
        d_rd      = '0;
        d_illegal = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        d_br  = 1'b1;
        d_imm = imm_b;
        d_rd  = '0;
        case (funct3)
          3'b000, 3'b001, 3'b100, 3'b101: d_op = ALU_SUB;
          3'b110:                         d_op = ALU_SLTU;
          3'b111:                         d_op = ALU_BGEU;
          default:                        d_illegal = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase
    // An illegal encoding zeroes the controls but keeps the raw register fields.
    if (d_illegal) begin
      d_op  = ALU_ADD;
      d_src = 1'b0;
      d_imm = '0;
      d_rs2 = bus.instr[24:20];
      d_rd  = bus.instr[11:7];
      d_rw  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_br  = 1'b0;
    end
  end

  logic                valid_q, in_ready, load;
  logic [3:0]          op_q;
  logic                src_q, rw_q, mr_q, mw_q, br_q, ill_q;
  logic [bitwidth-1:0] imm_q, pc_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic [2:0]          f3_q;

  assign in_ready = !valid_q || bus.out_ready || bus.flush;
  assign load     = bus.in_valid && in_ready && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      src_q   <= 1'b0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      f3_q    <= '0;
      pc_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      if (bus.flush)         valid_q <= 1'b0;
      else if (load)         valid_q <= 1'b1;
      else if (bus.out_ready) valid_q <= 1'b0;
      if (load) begin
        op_q  <= d_op;
        src_q <= d_src;
        imm_q <= d_imm;
        rs1_q <= bus.instr[19:15];
        rs2_q <= d_rs2;
        rd_q  <= d_rd;
        rw_q  <= d_rw;
        mr_q  <= d_mr;
        mw_q  <= d_mw;
        br_q  <= d_br;
        f3_q  <= funct3;
        pc_q  <= bus.pc_in;
        ill_q <= d_illegal;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = valid_q;
  assign bus.ALUOp      = op_q;
  assign bus.ALUSrc     = src_q;
  assign bus.imm        = imm_q;
  assign bus.rs1        = rs1_q;
  assign bus.rs2        = rs2_q;
  assign bus.rd         = rd_q;
  assign bus.reg_write  = rw_q;
  assign bus.mem_read   = mr_q;
  assign bus.mem_write  = mw_q;
  assign bus.branch     = br_q;
  assign bus.funct3_out = f3_q;
  assign bus.pc_out     = pc_q;
  assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_rv32_alu_decode_stage.sv
// Bench for rv32_alu_decode_stage: directed instruction cases plus a randomized
// handshake/flush run checked against a behavioural decode and pipeline model.
module tb_rv32_alu_decode_stage;
  typedef struct packed {
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic        illegal;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rv32_alu_decode_stage_if #(.bitwidth(32)) bus ();
  rv32_alu_decode_stage #(.bitwidth(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  bundle_t got;
  assign got = {bus.ALUOp, bus.ALUSrc, bus.imm, bus.rs1, bus.rs2, bus.rd, bus.reg_write,
                bus.mem_read, bus.mem_write, bus.branch, bus.funct3_out, bus.pc_out, bus.illegal};

  // Pipeline model state
  bit      m_valid = 1'b0;
  bundle_t m_b = '0;

  function automatic bundle_t mk(input logic [3:0] op, input logic src, input logic [31:0] imm,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic mw, input logic br,
                                 input logic [2:0] f3, input logic [31:0] pc, input logic ill);
    bundle_t b;
    b = {op, src, imm, rs1, rs2, rd, rw, mr, mw, br, f3, pc, ill};
    return b;
  endfunction

  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t    b;
    logic [3:0] base_op [8] = '{4'h0, 4'h7, 4'h5, 4'hA, 4'h4, 4'h6, 4'h3, 4'h2};
    int         f3 = int'(w[14:12]);
    int         f7 = int'(w[31:25]);
    logic [31:0] i_imm = 32'($signed(w) >>> 20);
    logic [31:0] s_imm = {i_imm[31:5], w[11:7]};
    logic [31:0] b_imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    bit          ok = 1'b0;
    b = '0;
    b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7]; b.funct3 = w[14:12]; b.pc = pc;
    case (w[6:0])
      7'h33: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        b.alu_op = (f7 == 32) ? ((f3 == 0) ? 4'h1 : 4'h9) : base_op[f3];
        b.reg_write = 1'b1;
      end
      7'h13: begin
        if (f3 == 1)      ok = (f7 == 0);
        else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
        else              ok = 1'b1;
        b.alu_op = (f3 == 5 && f7 == 32) ? 4'h9 : base_op[f3];
        b.imm = (f3 == 1 || f3 == 5) ? {27'd0, w[24:20]} : i_imm;
        b.alu_src = 1'b1; b.reg_write = 1'b1; b.rs2 = 5'd0;
      end
      7'h03: begin
        ok = !(f3 == 3 || f3 >= 6);
        b.alu_src = 1'b1; b.imm = i_imm; b.mem_read = 1'b1; b.reg_write = 1'b1;
      end
      7'h23: begin
        ok = (f3 <= 2);
        b.alu_src = 1'b1; b.imm = s_imm; b.mem_write = 1'b1; b.rd = 5'd0;
      end
      7'h63: begin
        ok = (f3 != 2 && f3 != 3);
        b.branch = 1'b1; b.imm = b_imm; b.rd = 5'd0;
        b.alu_op = (f3 == 6) ? 4'hA : (f3 == 7) ? 4'hB : 4'h1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      b.alu_op = 4'h0; b.alu_src = 1'b0; b.imm = 32'd0;
      b.reg_write = 1'b0; b.mem_read = 1'b0; b.mem_write = 1'b0; b.branch = 1'b0;
      b.rs2 = w[24:20]; b.rd = w[11:7]; b.illegal = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom();
    logic [6:0]  opc [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
    int          k = $urandom_range(0, 6);
    if (k < 6) w[6:0] = opc[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  // Advance one clock, updating the model from the inputs currently driven.
  task automatic cycle();
    bit ld = bus.in_valid && (!m_valid || bus.out_ready) && !bus.flush;
    if (bus.flush)          m_valid = 1'b0;
    else if (ld) begin      m_valid = 1'b1; m_b = ref_decode(bus.instr, bus.pc_in); end
    else if (bus.out_ready) m_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bus.in_valid = v; bus.instr = w; bus.pc_in = pc; bus.out_ready = rdy; bus.flush = fl;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (got !== bundle_t'('0)) begin errors++; $display("FAIL reset_bundle got %h exp 0", got); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_valid = 1'b0;
  endtask

  task automatic test_add();
    bundle_t e = mk(4'h0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 3'd0, 32'h100, 0);
    drive(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);
    cycle();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus.out_valid); end
    checks++; if (got !== e) begin errors++; $display("FAIL add_bundle got %h exp %h", got, e); end
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bundle_t e1 = mk(4'h1, 0, 32'h0, 5'd6, 5'd7, 5'd5, 1, 0, 0, 0, 3'd0, 32'h200, 0);
    bundle_t e2 = mk(4'h0, 1, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1, 0, 0, 0, 3'd0, 32'h204, 0);
    drive(1'b1, 32'h407302B3, 32'h200, 1'b1, 1'b0);
    cycle();
    checks++; if (got !== e1) begin errors++; $display("FAIL b2b_sub got %h exp %h", got, e1); end
    drive(1'b1, 32'hFFF00093, 32'h204, 1'b1, 1'b0);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", bus.in_ready); end
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || got !== e2) begin errors++; $display("FAIL b2b_addi got %b/%h exp 1/%h", bus.out_valid, got, e2); end
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_srai_bgeu();
    bundle_t e1 = mk(4'h9, 1, 32'h3, 5'd2, 5'd0, 5'd2, 1, 0, 0, 0, 3'd5, 32'h240, 0);
    bundle_t e2 = mk(4'hB, 0, 32'h8, 5'd1, 5'd2, 5'd0, 0, 0, 0, 1, 3'd7, 32'h244, 0);
    drive(1'b1, 32'h40315113, 32'h240, 1'b1, 1'b0);
    cycle();
    checks++; if (got !== e1) begin errors++; $display("FAIL srai got %h exp %h", got, e1); end
    drive(1'b1, 32'h0020F463, 32'h244, 1'b1, 1'b0);
    cycle();
    checks++; if (got !== e2) begin errors++; $display("FAIL bgeu got %h exp %h", got, e2); end
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_store_stall();
    bundle_t e1 = mk(4'h0, 1, 32'h4, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, 3'd2, 32'h300, 0);
    bundle_t e2 = mk(4'h0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 3'd0, 32'h304, 0);
    drive(1'b1, 32'h0020A223, 32'h300, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h002081B3, 32'h304, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b1 || got !== e1) begin errors++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/%h", i, bus.out_valid, got, e1); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
      cycle();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", bus.in_ready); end
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || got !== e2) begin errors++; $display("FAIL stall_next got %b/%h exp 1/%h", bus.out_valid, got, e2); end
    bus.in_valid = 1'b0;
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_illegal_flush();
    bundle_t e = mk(4'h0, 0, 32'h0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 3'd0, 32'h400, 1);
    drive(1'b1, 32'h02208033, 32'h400, 1'b1, 1'b0);
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL illegal_mul got %b/%h exp 1/%h", bus.out_valid, got, e); end
    drive(1'b1, 32'h002081B3, 32'h404, 1'b0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    bundle_t e = mk(4'h0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0, 3'd0, 32'h500, 0);
    drive(1'b1, 32'h002081B3, 32'h500, 1'b0, 1'b0);
    cycle();
    #2 rst_n = 1'b0;
    m_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b exp 0", bus.out_valid); end
    checks++; if (got !== bundle_t'('0)) begin errors++; $display("FAIL async_rst_bundle got %h exp 0", got); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_held got %b exp 0", bus.out_valid); end
    cycle();
    checks++; if (bus.out_valid !== 1'b1 || got !== e) begin errors++; $display("FAIL async_rst_reload got %b/%h exp 1/%h", bus.out_valid, got, e); end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), {$urandom()} & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      #1;
      checks++; if (bus.in_ready !== (!m_valid || bus.out_ready || bus.flush)) begin
        errors++; $display("FAIL rand_in_ready[%0d] got %b exp %b", n, bus.in_ready, !m_valid || bus.out_ready || bus.flush);
      end
      cycle();
      checks++; if (bus.out_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid[%0d] got %b exp %b", n, bus.out_valid, m_valid);
      end
      if (m_valid) begin
        checks++; if (got !== m_b) begin
          errors++; $display("FAIL rand_bundle[%0d] got %h exp %h", n, got, m_b);
        end
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_srai_bgeu();
    test_store_stall();
    test_illegal_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32_alu_decode_stage.md
# rv32_alu_decode_stage

Registered decode stage that turns a 32-bit RV32I instruction into the operation select, operand source select, immediate and control bits consumed by the execute-stage ALU. It sits between fetch and execute as the ID/EX pipeline register, with valid/ready handshakes on both sides. It also has a flush input for branch redirects. It covers the OP, OP-IMM, LOAD, STORE and BRANCH opcode groups and flags everything else as illegal.

## Interface
- bitwidth, 32: datapath width of `pc` and `imm` (instruction width is fixed at 32)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch offers `instr`/`pc_in`
- in_ready  out  1  stage accepts this cycle
- instr  in  32  instruction word
- pc_in  in  bitwidth  PC of `instr`
- flush  in  1  discard the held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes the bundle
- ALUOp  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SRL, 0111 SLL, 1001 SRA, 1010 SLTU, 1011 BGEU
- ALUSrc  out  1  1 = ALU operand B is `imm`
- imm  out  bitwidth  sign-extended immediate; zero-extended shamt for shift-immediates
- rs1, rs2, rd  out  5 each  register indices
- reg_write, mem_read, mem_write, branch  out  1 each  control strobes
- funct3_out  out  3  instr[14:12], passed through for branch condition and load/store size
- pc_out  out  bitwidth  registered `pc_in`
- illegal  out  1  unsupported encoding

## Operation
- Decode is combinational on `instr` and is captured into output registers on a load. A load is `in_valid && in_ready && !flush`.
- OP (0110011): funct7 0000000 selects by funct3: 000 ADD, 001 SLL, 010 SLT, 011 SLTU→1010, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7 0100000 is valid only with funct3 000 (SUB) and 101 (SRA). Any other funct7 is illegal.
  - ALUSrc=0, reg_write=1.
- OP-IMM (0010011): same mapping with no SUB.
  - imm is I-type sign-extended. SLLI/SRLI/SRAI instead give imm = {0, instr[24:20]}.
  - SLLI requires instr[31:25]=0000000. SRLI/SRAI require 0000000/0100000. Any other value is illegal.
  - ALUSrc=1, reg_write=1, rs2=0.
- LOAD (0000011): ADD, ALUSrc=1, I-imm, mem_read=1, reg_write=1. funct3 011, 110 and 111 are illegal.
- STORE (0100011): ADD, ALUSrc=1, S-imm, mem_write=1, rd=0. funct3 above 010 is illegal.
- BRANCH (1100011): branch=1, ALUSrc=0, imm = B-imm (bit 0 = 0), rd=0.
  - funct3 000/001/100/101 (BEQ/BNE/BLT/BGE) select SUB; execute reads the ALU's zero/less_than/greater_than_or_equal flags.
  - 110 (BLTU) selects 1010. 111 (BGEU) selects 1011.
  - 010 and 011 are illegal.
- Any other opcode, or instr[1:0] ≠ 11, is illegal.
- An illegal instruction still produces out_valid=1 with illegal=1. ALUOp=0000, ALUSrc=0, imm=0, and all four strobes are 0. rs1/rs2/rd/pc_out/funct3_out are passed through.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0. Every registered output is 0. in_ready follows its equation (1 while out_valid=0).
- in_ready = !out_valid || out_ready || flush (combinational). There is no path from in_valid to in_ready.
- Latency is 1 cycle from acceptance to out_valid. Full throughput is one instruction per cycle when out_ready is held at 1.
- While out_valid && !out_ready, every output holds stable and no new instruction is accepted.
- Clock edge with a load: out_valid=1 and the new bundle is registered.
- Clock edge with a consume (out_ready=1) and no load: out_valid=0.
- Clock edge with flush: out_valid=0 regardless of in_valid/out_ready. The incoming instruction is dropped, even though in_ready was 1 that cycle. Payload registers may hold stale values.
- Simultaneous consume and load: the new bundle replaces the old one with no bubble.
- rst_n deasserting mid-stream: the first possible load is at the first rising edge after release.

## Test plan
- 0x002081B3 (add x3,x1,x2), out_ready=1 → next cycle out_valid=1, ALUOp=0000, ALUSrc=0, rs1=1, rs2=2, rd=3, reg_write=1, illegal=0.
- Back-to-back 0x407302B3 (sub x5,x6,x7) then 0xFFF00093 (addi x1,x0,-1) → ALUOp 0001 then 0000 with ALUSrc=1, imm=0xFFFFFFFF, on consecutive cycles.
- 0x40315113 (srai x2,x2,3) → ALUOp=1001, imm=0x00000003, ALUSrc=1.
- 0x0020F463 (bgeu x1,x2,+8) → ALUOp=1011, branch=1, reg_write=0, imm=8, funct3_out=111.
- 0x0020A223 (sw x2,4(x1)) with out_ready=0 for 3 cycles → bundle (mem_write=1, imm=4, ALUOp=0000) stable and in_ready=0 throughout. Accepted next when out_ready rises.
- 0x02208033 (mul) → illegal=1 with all strobes 0. Then flush while holding a valid bundle and in_valid=1 → next cycle out_valid=0. Async rst_n pulse mid-stream → out_valid=0 immediately.
